ram_port_arbiter: RTL and testbench

Shares one single-port block RAM (15-bit address, 8-bit data, fixed read latency) between two requester engines, e.g. the UART receive/transmit engine and the signing engine's load/store engine. The phase sequencer no longer needs to mux addresses by phase. The block grants the RAM port in bursts using a round-robin policy with a burst-length cap. It tags every issued read so that read data returns to the requester that issued it, even after the grant has moved to the other requester.

---
 rtl/ram_port_arbiter.sv | 137 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin burst arbiter sharing one single-port RAM between requesters A and B.
// Ports: req/we/addr/wdata per side in; gnt/rvalid per side, shared rdata, RAM port, busy out.
module ram_port_arbiter #(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 256
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  localparam logic [15:0] CAP_CNT = 16'(MAX_BURST - 1);
  // Stages still waiting on the RAM; the last stage is the one being returned.
  localparam logic [RD_LAT-1:0] IN_MASK =
    RD_LAT'((1 << (RD_LAT - 1)) - 1);

  state_t state;
  state_t state_nxt;

  logic              last_b;
  logic [15:0]       cnt;
  logic              acc_a;
  logic              acc_b;
  logic              acc;
  logic              cap;
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_b;

  assign acc_a = (state == GNT_A) & req_a;
  assign acc_b = (state == GNT_B) & req_b;
  assign acc   = acc_a | acc_b;
  assign cap   = acc & (cnt == CAP_CNT);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_a & req_b)
          state_nxt = last_b ? GNT_A : GNT_B;
        else if (req_a)
          state_nxt = GNT_A;
        else if (req_b)
          state_nxt = GNT_B;
      end
      GNT_A: begin
        if (!req_a)
          state_nxt = req_b ? GNT_B : IDLE;
        else if (cap & req_b)
          state_nxt = GNT_B;
      end
      GNT_B: begin
        if (!req_b)
          state_nxt = req_a ? GNT_A : IDLE;
        else if (cap & req_a)
          state_nxt = GNT_A;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_a    = (state == GNT_A);
    gnt_b    = (state == GNT_B);
    ram_en   = acc;
    ram_we   = acc_a ? we_a : (acc_b & we_b);
    ram_addr = acc_b ? addr_b : addr_a;
    ram_din  = acc_b ? wdata_b : wdata_a;
  end

  // Burst count clears on any grant change and when a capped burst
  // keeps the grant because the other side is idle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_b <= 1'b1;
      cnt    <= '0;
    end else begin
      if (state_nxt != state && state_nxt != IDLE)
        last_b <= (state_nxt == GNT_B);
      if (state_nxt != state || cap)
        cnt <= '0;
      else if (acc)
        cnt <= cnt + 16'd1;
    end
  end

  // Tag pipeline follows each read to its return cycle regardless of grant.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tag_v <= '0;
      tag_b <= '0;
    end else begin
      tag_v[0] <= acc & ~ram_we;
      tag_b[0] <= acc_b;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_b[i] <= tag_b[i-1];
      end
    end
  end

  assign rvalid_a = tag_v[RD_LAT-1] & ~tag_b[RD_LAT-1];
  assign rvalid_b = tag_v[RD_LAT-1] &  tag_b[RD_LAT-1];
  assign rdata    = ram_dout;
  assign busy     = (state != IDLE) | (|(tag_v & IN_MASK));

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter (RD_LAT=2, MAX_BURST=4)
// with a behavioural 2-cycle-latency RAM.
module tb_ram_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req_a, req_b, we_a, we_b;
  logic [14:0] addr_a, addr_b;
  logic [7:0]  wdata_a, wdata_b;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [7:0]  rdata;
  logic        ram_en, ram_we;
  logic [14:0] ram_addr;
  logic [7:0]  ram_din, ram_dout;
  logic        busy;

  int checks = 0;
  int failures = 0;

  ram_port_arbiter #(
    .ADDR_W(15), .DATA_W(8), .RD_LAT(2), .MAX_BURST(4)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .req_a(req_a), .req_b(req_b),
    .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata(rdata),
    .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy)
  );

  logic [7:0] mem [32768];
  logic [7:0] d1, d2;

  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_din;
    d1 <= mem[ram_addr];
    d2 <= d1;
  end
  assign ram_dout = d2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    req_a = 1'b1; req_b = 1'b1;
    we_a = 1'b0; we_b = 1'b0;
    addr_a = '0; addr_b = '0;
    wdata_a = '0; wdata_b = '0;

    // Reset held with both requests high
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt_a", gnt_a, 0);
    chk("rst_gnt_b", gnt_b, 0);
    chk("rst_rvalid_a", rvalid_a, 0);
    chk("rst_rvalid_b", rvalid_b, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_busy", busy, 0);
    nxt();
    rst_n = 1'b1;
    @(negedge clk);
    chk("tie_pre_gnt_a", gnt_a, 0);
    nxt();
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    chk("tie_gnt_a", gnt_a, 1);
    chk("tie_gnt_b", gnt_b, 0);
    chk("tie_no_acc", ram_en, 0);
    nxt();
    @(negedge clk);
    chk("tie_idle", gnt_a, 0);

    // B writes 0..3 then reads them back
    nxt();
    req_b = 1'b1; we_b = 1'b1; addr_b = 15'd0; wdata_b = 8'h10;
    @(negedge clk);
    chk("s2_gnt_lat", gnt_b, 0);
    for (int k = 1; k <= 11; k++) begin
      nxt();
      if (k <= 4) begin
        we_b = 1'b1; addr_b = 15'(k - 1); wdata_b = 8'(8'h10 + k - 1);
      end else if (k <= 8) begin
        we_b = 1'b0; addr_b = 15'(k - 5);
      end else begin
        req_b = 1'b0; we_b = 1'b0;
      end
      @(negedge clk);
      chk("s2_gnt_b", gnt_b, (k <= 9));
      chk("s2_ram_en", ram_en, (k <= 8));
      if (k <= 8) begin
        chk("s2_ram_we", ram_we, (k <= 4));
        chk("s2_ram_addr", ram_addr, (k <= 4) ? k - 1 : k - 5);
      end
      chk("s2_rvalid_b", rvalid_b, (k >= 7 && k <= 10));
      if (k >= 7 && k <= 10) chk("s2_rdata", rdata, 8'h10 + k - 7);
      chk("s2_rvalid_a", rvalid_a, 0);
      chk("s2_busy", busy, (k <= 9));
    end

    // Burst cap handover A -> B -> A
    nxt();
    req_a = 1'b1; we_a = 1'b1; addr_a = 15'h20; wdata_a = 8'h00;
    for (int k = 1; k <= 11; k++) begin
      nxt();
      req_a = (k <= 9); we_a = 1'b1;
      addr_a = 15'(15'h20 + k); wdata_a = 8'(k);
      req_b = (k >= 2 && k <= 9); we_b = 1'b1;
      addr_b = 15'(15'h40 + k); wdata_b = 8'(k);
      @(negedge clk);
      chk("s3_gnt_a", gnt_a, (k <= 4 || k == 9 || k == 10));
      chk("s3_gnt_b", gnt_b, (k >= 5 && k <= 8));
      chk("s3_ram_en", ram_en, (k <= 9));
      if (k <= 9)
        chk("s3_ram_addr", ram_addr,
            (k >= 5 && k <= 8) ? 32'h40 + k : 32'h20 + k);
    end
    req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;

    // Reads in flight survive a grant switch to B
    nxt();
    req_a = 1'b1; we_a = 1'b0; addr_a = 15'd0;
    for (int k = 1; k <= 8; k++) begin
      nxt();
      req_a = (k <= 4); we_a = 1'b0; addr_a = 15'(k - 1);
      req_b = (k >= 2 && k <= 6); we_b = 1'b1;
      addr_b = 15'h50; wdata_b = 8'hEE;
      @(negedge clk);
      chk("s4_gnt_a", gnt_a, (k <= 4));
      chk("s4_gnt_b", gnt_b, (k >= 5 && k <= 7));
      chk("s4_rvalid_a", rvalid_a, (k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) chk("s4_rdata", rdata, 8'h10 + k - 3);
      chk("s4_rvalid_b", rvalid_b, 0);
    end
    we_b = 1'b0;

    // A releases after 5 reads with B idle
    nxt();
    req_a = 1'b1; we_a = 1'b0; addr_a = 15'd0;
    for (int k = 1; k <= 8; k++) begin
      nxt();
      req_a = (k <= 5); addr_a = 15'(k - 1);
      @(negedge clk);
      chk("s5_gnt_a", gnt_a, (k <= 6));
      chk("s5_ram_en", ram_en, (k <= 5));
      chk("s5_rvalid_a", rvalid_a, (k >= 3 && k <= 7));
      if (k >= 3 && k <= 7)
        chk("s5_rdata", rdata, (k - 3 < 4) ? 8'h10 + k - 3 : 0);
      chk("s5_busy", busy, (k <= 6));
    end

    // Reset one cycle after a read access
    nxt();
    req_a = 1'b1; addr_a = 15'd1;
    nxt();
    @(negedge clk);
    chk("s6_read_acc", ram_en, 1);
    nxt();
    req_a = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("s6_rst_rvalid", rvalid_a, 0);
    chk("s6_rst_busy", busy, 0);
    nxt();
    rst_n = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      chk("s6_rvalid_a", rvalid_a, 0);
      chk("s6_gnt_a", gnt_a, 0);
      chk("s6_busy", busy, 0);
      nxt();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
